// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C write controller between two requesters,
// with NACK/timeout retry, inter-try bus gap and a single completion pulse per request.
module i2c_bus_arbiter #(
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 64,
  parameter int GAP_TICKS     = 2
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  req,
  input  logic [23:0] wdata0,
  input  logic [23:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic        ctl_start,
  output logic [23:0] ctl_data,
  input  logic        ctl_done,
  input  logic        ctl_ack_n
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);

  // state | meaning
  // IDLE  | no transaction, waiting for any req
  // WAIT  | ctl_start held, waiting for ctl_done or timeout
  // GAP   | bus idle between a failed try and its retry
  // RESP  | one-cycle done/err pulse to the winner
  typedef enum logic [1:0] {IDLE, WAIT, GAP, RESP} state_t;

  state_t        state;
  logic          win;
  logic          last;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;

  logic pick;
  logic acked;
  logic try_fail;

  // On a tie the requester that was not served last wins.
  assign pick     = (&req) ? ~last : req[1];
  assign acked    = ctl_done & ~ctl_ack_n;
  // A timeout counts as a failed try like a NACK; ctl_done beats a coincident timeout tick.
  assign try_fail = (ctl_done & ctl_ack_n) | (~ctl_done & tick & (timer == TIMER_LAST));

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      win       <= 1'b0;
      last      <= 1'b1;
      retry_cnt <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      err       <= 2'b00;
      busy      <= 1'b0;
      ctl_start <= 1'b0;
      ctl_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          err  <= 2'b00;
          if (|req) begin
            win       <= pick;
            gnt       <= {pick, ~pick};
            ctl_data  <= pick ? wdata1 : wdata0;
            ctl_start <= 1'b1;
            retry_cnt <= '0;
            timer     <= '0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (acked) begin
            ctl_start <= 1'b0;
            done      <= {win, ~win};
            err       <= 2'b00;
            state     <= RESP;
          end else if (try_fail) begin
            ctl_start <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              done  <= {win, ~win};
              err   <= {win, ~win};
              state <= RESP;
            end
          end else if (tick) begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              timer     <= '0;
              ctl_start <= 1'b1;
              state     <= WAIT;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          done  <= 2'b00;
          err   <= 2'b00;
          gnt   <= 2'b00;
          last  <= win;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant/round-robin, NACK retry, timeout,
// done/err pulses and asynchronous reset.
module tb_i2c_bus_arbiter;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic        tick;
  logic [1:0]  req;
  logic [23:0] wdata0, wdata1;
  logic [1:0]  gnt, done, err;
  logic        busy, ctl_start;
  logic [23:0] ctl_data;
  logic        ctl_done, ctl_ack_n;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int starts    = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int gnt1_seen = 0;
  logic prev_start = 1'b0;
  int s0, d0;

  i2c_bus_arbiter #(.MAX_RETRY(3), .TIMEOUT_TICKS(64), .GAP_TICKS(2)) dut (
    .clock_25 (clock_25),
    .reset    (reset),
    .tick     (tick),
    .req      (req),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .ctl_start(ctl_start),
    .ctl_data (ctl_data),
    .ctl_done (ctl_done),
    .ctl_ack_n(ctl_ack_n)
  );

  always #5 clock_25 = ~clock_25;

  always @(negedge clock_25) begin
    if (ctl_start && !prev_start) starts++;
    prev_start = ctl_start;
    if (done[0]) done_cnt0++;
    if (done[1]) done_cnt1++;
    if (gnt[1]) gnt1_seen++;
  end

  task automatic step();
    @(posedge clock_25);
    #1;
  endtask

  task automatic tick_edge();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_edge();
      step();
    end
  endtask

  task automatic finish_xfer(input logic nack);
    ctl_done  = 1'b1;
    ctl_ack_n = nack;
    step();
    ctl_done  = 1'b0;
    ctl_ack_n = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; req = 2'b00;
    wdata0 = 24'h724110; wdata1 = 24'hABCDEF;
    ctl_done = 1'b0; ctl_ack_n = 1'b0;
    step(); step(); step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_start", ctl_start, 0);
    chk("rst_data", ctl_data, 0);
    reset = 1'b1;
    do_ticks(2);
    chk("idle_tick_busy", busy, 0);

    // single write from requester 0
    gnt1_seen = 0;
    req = 2'b01;
    step();
    chk("sw_gnt", gnt, 2'b01);
    chk("sw_start", ctl_start, 1);
    chk("sw_data", ctl_data, 24'h724110);
    chk("sw_busy", busy, 1);
    do_ticks(30);
    chk("sw_start_held", ctl_start, 1);
    finish_xfer(1'b0);
    chk("sw_done", done, 2'b01);
    chk("sw_err", err, 2'b00);
    chk("sw_start_drop", ctl_start, 0);
    req = 2'b00;
    step();
    chk("sw_done_clr", done, 2'b00);
    chk("sw_gnt_clr", gnt, 2'b00);
    step();
    chk("sw_busy_low", busy, 0);
    chk("sw_done_count", done_cnt0, 1);
    chk("sw_gnt1_never", gnt1_seen, 0);

    // simultaneous requests straight after reset, kept asserted
    reset = 1'b0; step(); reset = 1'b1;
    req = 2'b11;
    step();
    chk("tie1_gnt", gnt, 2'b01);
    chk("tie1_data", ctl_data, 24'h724110);
    finish_xfer(1'b0);
    chk("tie1_done", done, 2'b01);
    step();
    chk("tie1_gap_gnt", gnt, 2'b00);
    step();
    chk("tie2_gnt", gnt, 2'b10);
    chk("tie2_data", ctl_data, 24'hABCDEF);
    finish_xfer(1'b0);
    chk("tie2_done", done, 2'b10);
    step(); step();
    chk("tie3_gnt", gnt, 2'b01);
    finish_xfer(1'b0);
    req = 2'b00;
    step(); step();

    // NACK, NACK, ACK on requester 1
    wdata1 = 24'h5A0311;
    s0 = starts;
    req = 2'b10;
    step();
    chk("nk_gnt", gnt, 2'b10);
    do_ticks(3);
    finish_xfer(1'b1);
    chk("nk_gap_start", ctl_start, 0);
    chk("nk_gap_busy", busy, 1);
    finish_xfer(1'b0);
    chk("nk_gap_ignore_done", done, 2'b00);
    do_ticks(1);
    chk("nk_gap_tick1", ctl_start, 0);
    do_ticks(1);
    chk("nk_gap_tick2", ctl_start, 1);
    chk("nk_data_hold", ctl_data, 24'h5A0311);
    wdata1 = 24'h000000;
    req = 2'b00;
    do_ticks(5);
    finish_xfer(1'b1);
    do_ticks(2);
    finish_xfer(1'b0);
    chk("nk_done", done, 2'b10);
    chk("nk_err", err, 2'b00);
    chk("nk_data_end", ctl_data, 24'h5A0311);
    step(); step();
    chk("nk_starts", starts - s0, 3);

    // persistent NACK on requester 0
    wdata0 = 24'h123456;
    s0 = starts;
    req = 2'b01;
    step();
    for (int i = 0; i < 3; i++) begin
      finish_xfer(1'b1);
      chk("pn_no_done", done, 2'b00);
      do_ticks(2);
    end
    finish_xfer(1'b1);
    chk("pn_done", done, 2'b01);
    chk("pn_err", err, 2'b01);
    req = 2'b00;
    step(); step();
    chk("pn_starts", starts - s0, 4);
    chk("pn_idle", busy, 0);

    // timeouts on every try, requester 1
    s0 = starts;
    req = 2'b10;
    step();
    for (int i = 0; i < 4; i++) begin
      do_ticks(63);
      chk("to_start_63", ctl_start, 1);
      tick_edge();
      if (i < 3) begin
        chk("to_start_drop", ctl_start, 0);
        chk("to_no_done", done, 2'b00);
        step();
        do_ticks(2);
      end else begin
        chk("to_done", done, 2'b10);
        chk("to_err", err, 2'b10);
        req = 2'b00;
        step();
      end
    end
    step();
    chk("to_starts", starts - s0, 4);

    // ctl_done together with the timeout tick wins
    req = 2'b01;
    step();
    do_ticks(63);
    tick = 1'b1; ctl_done = 1'b1; ctl_ack_n = 1'b0;
    step();
    tick = 1'b0; ctl_done = 1'b0;
    chk("tod_done", done, 2'b01);
    chk("tod_err", err, 2'b00);
    req = 2'b00;
    step(); step();

    // asynchronous reset in the middle of a requester 1 transaction
    req = 2'b10;
    step();
    chk("ar_gnt", gnt, 2'b10);
    do_ticks(5);
    d0 = done_cnt0 + done_cnt1;
    reset = 1'b0;
    #1;
    chk("ar_gnt0", gnt, 2'b00);
    chk("ar_start0", ctl_start, 0);
    chk("ar_busy0", busy, 0);
    chk("ar_data0", ctl_data, 0);
    req = 2'b11;
    step();
    chk("ar_done_none", done, 2'b00);
    reset = 1'b1;
    step();
    chk("ar_gnt_after", gnt, 2'b01);
    chk("ar_no_pulse", done_cnt0 + done_cnt1 - d0, 0);
    finish_xfer(1'b0);
    req = 2'b00;
    step(); step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
